// File: rtl/fridge_compressor_ctrl_pkg.sv
// Shared definitions for the fridge compressor controller: temperature code width,
// FSM state encoding and damper routing constants.
package fridge_compressor_ctrl_pkg;

    localparam int TEMP_W = 5;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COOL_FR = 2'd2,
        ST_COOL_FG = 2'd3
    } state_e;

    localparam logic DAMPER_FREEZER = 1'b0;
    localparam logic DAMPER_FRIDGE  = 1'b1;

    // Compartment indices for the per-compartment demand comparators.
    localparam int CMP_FR = 0;
    localparam int CMP_FG = 1;

    function automatic logic is_cooling(state_e s);
        return (s == ST_COOL_FR) || (s == ST_COOL_FG);
    endfunction

endpackage

// File: rtl/fridge_compressor_ctrl_hyst_cmp.sv
// Registered hysteresis comparator: demand sets above setpoint+HYST, clears at or
// below setpoint, and holds in between.
module fridge_hyst_cmp
    import fridge_compressor_ctrl_pkg::*;
#(
    parameter int HYST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] sense,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              dem
);

    localparam logic [TEMP_W:0] HYST_C = HYST[TEMP_W:0];

    logic [TEMP_W:0] upper_thr;
    logic            dem_q;

    // One extra bit so setpoint+HYST never wraps.
    assign upper_thr = {1'b0, setpoint} + HYST_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            dem_q <= 1'b0;
        end else if ({1'b0, sense} > upper_thr) begin
            dem_q <= 1'b1;
        end else if (sense <= setpoint) begin
            dem_q <= 1'b0;
        end
    end

    assign dem = dem_q;

endmodule

// File: rtl/fridge_compressor_ctrl.sv
// Compressor/damper thermostat with minimum run/rest protection and a door-open alarm.
// All outputs are registered.
module fridge_compressor_ctrl
    import fridge_compressor_ctrl_pkg::*;
#(
    parameter int HYST    = 1,
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 8,
    parameter int DOOR_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr,
    input  logic [TEMP_W-1:0] fgt,
    input  logic [TEMP_W-1:0] frt,
    input  logic [TEMP_W-1:0] fg_sense,
    input  logic [TEMP_W-1:0] fr_sense,
    input  logic              door_open,
    output logic              comp_on,
    output logic              damper,
    output logic              alarm,
    output logic [1:0]        state
);

    localparam int RW = $clog2(MIN_OFF + 1);
    localparam int NW = $clog2(MIN_ON + 1);
    localparam int DW = $clog2(DOOR_TO + 1);

    localparam logic [RW-1:0] REST_MAX = RW'(MIN_OFF);
    localparam logic [NW-1:0] RUN_MAX  = NW'(MIN_ON);
    localparam logic [DW-1:0] DOOR_MAX = DW'(DOOR_TO);

    logic [TEMP_W-1:0] sense_a [2];
    logic [TEMP_W-1:0] setp_a  [2];
    logic [1:0]        dem;

    assign sense_a[CMP_FR] = fr_sense;
    assign sense_a[CMP_FG] = fg_sense;
    assign setp_a[CMP_FR]  = frt;
    assign setp_a[CMP_FG]  = fgt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
        fridge_hyst_cmp #(.HYST(HYST)) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .sense    (sense_a[gi]),
            .setpoint (setp_a[gi]),
            .dem      (dem[gi])
        );
    end

    logic fr_dem;
    logic fg_dem;
    assign fr_dem = dem[CMP_FR];
    assign fg_dem = dem[CMP_FG];

    state_e        state_q, state_d;
    logic          comp_q, comp_d;
    logic          damper_q, damper_d;
    logic          alarm_q, alarm_d;
    logic [RW-1:0] rest_q, rest_d;
    logic [NW-1:0] run_q, run_d;
    logic [DW-1:0] door_q, door_d;

    logic rest_done;
    logic run_done;
    assign rest_done = (rest_q >= REST_MAX);
    assign run_done  = (run_q >= RUN_MAX);

    always_comb begin
        state_d  = state_q;
        rest_d   = rest_q;
        run_d    = run_q;
        damper_d = damper_q;

        if (!pwr) begin
            state_d = ST_OFF;
            rest_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!rest_done) rest_d = rest_q + RW'(1);
                    if (rest_done && fr_dem) begin
                        state_d = ST_COOL_FR;
                        run_d   = '0;
                    end else if (rest_done && fg_dem) begin
                        state_d = ST_COOL_FG;
                        run_d   = '0;
                    end
                end
                ST_COOL_FR: begin
                    if (!run_done) run_d = run_q + NW'(1);
                    if (!fr_dem && fg_dem) begin
                        state_d = ST_COOL_FG;
                    end else if (!fr_dem && !fg_dem && run_done) begin
                        state_d = ST_IDLE;
                        rest_d  = '0;
                    end
                end
                ST_COOL_FG: begin
                    if (!run_done) run_d = run_q + NW'(1);
                    if (fr_dem) begin
                        state_d = ST_COOL_FR;
                    end else if (!fg_dem && run_done) begin
                        state_d = ST_IDLE;
                        rest_d  = '0;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Outputs follow the next state so they stay aligned with the state register.
        comp_d = is_cooling(state_d);
        if (state_d == ST_COOL_FR) damper_d = DAMPER_FREEZER;
        else if (state_d == ST_COOL_FG) damper_d = DAMPER_FRIDGE;

        if (!door_open)            door_d = '0;
        else if (door_q < DOOR_MAX) door_d = door_q + DW'(1);
        else                       door_d = door_q;
        alarm_d = pwr && (door_d == DOOR_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            comp_q   <= 1'b0;
            damper_q <= DAMPER_FREEZER;
            alarm_q  <= 1'b0;
            rest_q   <= REST_MAX;
            run_q    <= '0;
            door_q   <= '0;
        end else begin
            state_q  <= state_d;
            comp_q   <= comp_d;
            damper_q <= damper_d;
            alarm_q  <= alarm_d;
            rest_q   <= rest_d;
            run_q    <= run_d;
            door_q   <= door_d;
        end
    end

    assign comp_on = comp_q;
    assign damper  = damper_q;
    assign alarm   = alarm_q;
    assign state   = state_q;

endmodule
